// File: rtl/surf_cmd_pkg.sv
// Shared definitions for the SURF CMD-line receiver: FSM encoding and frame line levels.
package surf_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // Start, parity and stop bits wrapped around the payload.
  localparam int FRAME_OVH_BITS = 3;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;

  function automatic int frame_bits(input int nbits);
    return nbits + FRAME_OVH_BITS;
  endfunction

endpackage

// File: rtl/cmd_line_sync.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module cmd_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/surf_cmd_receiver.sv
// SURF-side receiver for the TURF->SURF CMD line: mid-bit sampling of start/data/parity/stop,
// one-cycle strobes for good words and for parity/framing errors, saturating error counters.
module surf_cmd_receiver
  import surf_cmd_pkg::*;
#(
  parameter int NBITS    = 16,
  parameter int BIT_CLKS = 4,
  parameter int CNT_W    = 8
) (
  input  logic             CLK125,
  input  logic             reset_n_i,
  input  logic             cmd_i,
  output logic [NBITS-1:0] cmd_data_o,
  output logic             cmd_valid_o,
  output logic             busy_o,
  output logic             par_err_o,
  output logic             frm_err_o,
  output logic [CNT_W-1:0] par_err_cnt_o,
  output logic [CNT_W-1:0] frm_err_cnt_o
);

  localparam int TICK_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int IDX_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int HALF   = BIT_CLKS / 2;

  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(BIT_CLKS - 1);
  localparam logic [TICK_W-1:0] TICK_FIRST  = TICK_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NBITS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             rst_int_n;
  logic             s;
  state_e           state_q;
  logic [TICK_W-1:0] tick_q;
  logic [IDX_W-1:0] idx_q;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] shift_d;
  logic             parity_ok_q;
  logic [NBITS-1:0] data_q;
  logic             valid_q;
  logic             par_err_q;
  logic             frm_err_q;
  logic [CNT_W-1:0] par_cnt_q;
  logic [CNT_W-1:0] frm_cnt_q;
  logic             sample;

  // Reset asserts immediately but releases in step with CLK125.
  cmd_line_sync u_rst_sync (
    .clk_i  (CLK125),
    .rst_ni (reset_n_i),
    .d_i    (1'b1),
    .q_o    (rst_int_n)
  );

  cmd_line_sync u_cmd_sync (
    .clk_i  (CLK125),
    .rst_ni (reset_n_i),
    .d_i    (cmd_i),
    .q_o    (s)
  );

  assign sample  = (tick_q == '0);
  assign shift_d = {shift_q[NBITS-2:0], s};

  // Payload shifter carries no reset; only valid frames ever reach data_q.
  always_ff @(posedge CLK125) begin
    if (state_q == ST_DATA && sample) begin
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge CLK125 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      idx_q       <= '0;
      parity_ok_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      par_cnt_q   <= '0;
      frm_cnt_q   <= '0;
    end else begin
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      if (state_q != ST_IDLE && state_q != ST_BREAK) begin
        tick_q <= sample ? TICK_RELOAD : tick_q - TICK_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (s == START_LEVEL) begin
            // With a zero half-period the detection cycle is itself the start sample.
            if (HALF == 0) begin
              state_q <= ST_DATA;
              idx_q   <= IDX_LAST;
              tick_q  <= TICK_RELOAD;
            end else begin
              state_q <= ST_START;
              tick_q  <= TICK_FIRST;
            end
          end
        end
        ST_START: begin
          if (sample) begin
            if (s == START_LEVEL) begin
              state_q <= ST_DATA;
              idx_q   <= IDX_LAST;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            if (idx_q == '0) begin
              state_q <= ST_PARITY;
            end else begin
              idx_q <= idx_q - IDX_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (sample) begin
            parity_ok_q <= ^{shift_q, s};
            state_q     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            if (s != IDLE_LEVEL) begin
              frm_err_q <= 1'b1;
              frm_cnt_q <= sat_inc(frm_cnt_q);
              state_q   <= ST_BREAK;
            end else if (parity_ok_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
              state_q <= ST_IDLE;
            end else begin
              par_err_q <= 1'b1;
              par_cnt_q <= sat_inc(par_cnt_q);
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (s == IDLE_LEVEL) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_data_o    = data_q;
  assign cmd_valid_o   = valid_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign par_err_o     = par_err_q;
  assign frm_err_o     = frm_err_q;
  assign par_err_cnt_o = par_cnt_q;
  assign frm_err_cnt_o = frm_cnt_q;

endmodule

// File: tb/tb_surf_cmd_receiver.sv
// Directed bench for surf_cmd_receiver: vector table of frames plus hand-built corner sequences.
module tb_surf_cmd_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd4 = 1'b0;
  logic        cmd1 = 1'b0;

  logic [15:0] data4, data1;
  logic        valid4, busy4, par4, frm4;
  logic        valid1, busy1, par1, frm1;
  logic [7:0]  pcnt4, fcnt4, pcnt1, fcnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int v4 = 0, p4 = 0, f4 = 0, v4_cyc = 0;
  int v1 = 0, e1 = 0;
  logic [15:0] d1 [4];

  surf_cmd_receiver #(.NBITS(16), .BIT_CLKS(4), .CNT_W(8)) dut4 (
    .CLK125(clk), .reset_n_i(reset_n), .cmd_i(cmd4),
    .cmd_data_o(data4), .cmd_valid_o(valid4), .busy_o(busy4),
    .par_err_o(par4), .frm_err_o(frm4),
    .par_err_cnt_o(pcnt4), .frm_err_cnt_o(fcnt4)
  );

  surf_cmd_receiver #(.NBITS(16), .BIT_CLKS(1), .CNT_W(8)) dut1 (
    .CLK125(clk), .reset_n_i(reset_n), .cmd_i(cmd1),
    .cmd_data_o(data1), .cmd_valid_o(valid1), .busy_o(busy1),
    .par_err_o(par1), .frm_err_o(frm1),
    .par_err_cnt_o(pcnt1), .frm_err_cnt_o(fcnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobes are one cycle wide, so each negedge sees a given strobe exactly once.
  always @(negedge clk) begin
    if (valid4) begin
      v4 = v4 + 1;
      v4_cyc = cyc;
    end
    if (par4) p4 = p4 + 1;
    if (frm4) f4 = f4 + 1;
    if (valid1) begin
      if (v1 < 4) d1[v1] = data1;
      v1 = v1 + 1;
    end
    if (par1 || frm1) e1 = e1 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bit4(input logic b);
    cmd4 = b;
    tick(4);
  endtask

  task automatic send4(input logic [15:0] d, input logic flip, input logic stop);
    logic p;
    p = (~^d) ^ flip;
    tick(1);
    start_cyc = cyc;
    bit4(1'b1);
    for (int i = 15; i >= 0; i--) bit4(d[i]);
    bit4(p);
    bit4(stop);
  endtask

  task automatic clear_counts();
    v4 = 0; p4 = 0; f4 = 0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic        flip;
    int          exp_v;
    int          exp_p;
    logic [15:0] exp_data;
    int          exp_pcnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'hA5C3, 1'b0, 1, 0, 16'hA5C3, 0};
    vecs[1] = '{16'hA5C3, 1'b1, 0, 1, 16'hA5C3, 1};
    vecs[2] = '{16'h0001, 1'b0, 1, 0, 16'h0001, 1};
    vecs[3] = '{16'hFFFF, 1'b0, 1, 0, 16'hFFFF, 1};
    vecs[4] = '{16'h0000, 1'b0, 1, 0, 16'h0000, 1};
    vecs[5] = '{16'h8000, 1'b1, 0, 1, 16'h0000, 2};

    tick(3);
    check("rst_data", 32'(data4), 32'h0);
    check("rst_valid", 32'(valid4), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_pcnt", 32'(pcnt4), 32'h0);
    check("rst_fcnt", 32'(fcnt4), 32'h0);
    reset_n = 1'b1;
    tick(5);

    for (int i = 0; i < 6; i++) begin
      clear_counts();
      send4(vecs[i].data, vecs[i].flip, 1'b0);
      tick(12);
      check($sformatf("vec%0d_valid", i), 32'(v4), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_parstb", i), 32'(p4), 32'(vecs[i].exp_p));
      check($sformatf("vec%0d_frmstb", i), 32'(f4), 32'h0);
      check($sformatf("vec%0d_data", i), 32'(data4), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_pcnt", i), 32'(pcnt4), 32'(vecs[i].exp_pcnt));
      check($sformatf("vec%0d_busy", i), 32'(busy4), 32'h0);
      if (i == 0) check("latency", 32'(v4_cyc - start_cyc), 32'd77);
    end

    // Stop bit high, line stuck high afterwards.
    clear_counts();
    send4(16'h5A5A, 1'b0, 1'b1);
    tick(20);
    check("frm_strobe", 32'(f4), 32'd1);
    check("frm_parstb", 32'(p4), 32'd0);
    check("frm_valid", 32'(v4), 32'd0);
    check("frm_busy_high", 32'(busy4), 32'd1);
    check("frm_cnt", 32'(fcnt4), 32'd1);
    check("frm_data_kept", 32'(data4), 32'h0000);
    cmd4 = 1'b0;
    tick(6);
    check("frm_busy_low", 32'(busy4), 32'd0);
    clear_counts();
    send4(16'h0001, 1'b0, 1'b0);
    tick(12);
    check("after_break_valid", 32'(v4), 32'd1);
    check("after_break_data", 32'(data4), 32'h0001);

    // One-cycle glitch on the idle line.
    clear_counts();
    tick(1);
    cmd4 = 1'b1;
    tick(1);
    cmd4 = 1'b0;
    tick(10);
    check("glitch_strobes", 32'(v4 + p4 + f4), 32'd0);
    check("glitch_busy", 32'(busy4), 32'd0);
    check("glitch_pcnt", 32'(pcnt4), 32'd2);
    check("glitch_fcnt", 32'(fcnt4), 32'd1);

    // Saturation of the parity error counter.
    clear_counts();
    for (int k = 0; k < 300; k++) begin
      send4(16'h00FF, 1'b1, 1'b0);
      tick(2);
    end
    tick(10);
    check("sat_pcnt", 32'(pcnt4), 32'd255);
    check("sat_parstb", 32'(p4), 32'd300);
    check("sat_valid", 32'(v4), 32'd0);
    check("sat_data", 32'(data4), 32'h0001);

    // Reset in the middle of the data bits.
    tick(1);
    bit4(1'b1);
    for (int i = 15; i >= 8; i--) bit4(1'b1);
    check("mid_busy", 32'(busy4), 32'd1);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_data", 32'(data4), 32'h0);
    check("mid_rst_pcnt", 32'(pcnt4), 32'h0);
    check("mid_rst_fcnt", 32'(fcnt4), 32'h0);
    check("mid_rst_busy", 32'(busy4), 32'h0);
    cmd4 = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6);
    clear_counts();
    send4(16'h1234, 1'b0, 1'b0);
    tick(12);
    check("post_rst_valid", 32'(v4), 32'd1);
    check("post_rst_data", 32'(data4), 32'h1234);
    check("post_rst_errs", 32'(p4 + f4), 32'd0);

    // Back-to-back frames on the one-clock-per-bit receiver.
    v1 = 0; e1 = 0;
    tick(1);
    begin
      logic [18:0] fa, fb;
      fa = {1'b1, 16'hFFFF, 1'b1, 1'b0};
      fb = {1'b1, 16'h0000, 1'b1, 1'b0};
      for (int i = 18; i >= 0; i--) begin cmd1 = fa[i]; tick(1); end
      for (int i = 18; i >= 0; i--) begin cmd1 = fb[i]; tick(1); end
      cmd1 = 1'b0;
    end
    tick(10);
    check("b2b_count", 32'(v1), 32'd2);
    check("b2b_first", 32'(d1[0]), 32'hFFFF);
    check("b2b_second", 32'(d1[1]), 32'h0000);
    check("b2b_errs", 32'(e1), 32'd0);
    check("b2b_busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
